alu_ext_issue: RTL and testbench

ALU_EXT_ISSUE -- requirements
Module: alu_ext_issue

---
 rtl/alu_ext_issue_pkg.sv | 40 ++++
 rtl/alu_ext_lat_lut.sv | 30 +++
 rtl/alu_ext_issue.sv | 166 ++++++++++++++++
 tb/tb_alu_ext_issue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ext_issue_pkg.sv
// Shared definitions for the ALU_EXT issue block.
// Holds the ALU_EXT func encodings, the issuer FSM state type, the default
// per-class latencies and a small helper for sizing the latency counter.
package alu_ext_issue_pkg;

  // ALU_EXT func encodings
  localparam logic [2:0] FUNC_MUL   = 3'b000;
  localparam logic [2:0] FUNC_UMUL  = 3'b001;
  localparam logic [2:0] FUNC_ADDF  = 3'b010;
  localparam logic [2:0] FUNC_SUBF  = 3'b011;
  localparam logic [2:0] FUNC_MULF  = 3'b100;
  localparam logic [2:0] FUNC_ITF   = 3'b101;
  localparam logic [2:0] FUNC_FTI   = 3'b110;
  localparam logic [2:0] FUNC_UNDEF = 3'b111;

  // Default latencies (cycles from issue to a valid ALU_EXT result)
  localparam int unsigned DEF_LAT_IMUL = 2;
  localparam int unsigned DEF_LAT_FADD = 3;
  localparam int unsigned DEF_LAT_FMUL = 3;
  localparam int unsigned DEF_LAT_CVT  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_e;

  // Largest latency of all classes; the undefined func counts as latency 1.
  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/alu_ext_lat_lut.sv
// Combinational func -> latency lookup for ALU_EXT ops.
// Ports:
//   func  in   3      ALU_EXT func encoding
//   lat   out  CNT_W  latency in cycles for that func (undefined func -> 1)
// Every LAT_* parameter must be >= 1.
module alu_ext_lat_lut
  import alu_ext_issue_pkg::*;
#(
  parameter int unsigned LAT_IMUL = DEF_LAT_IMUL,
  parameter int unsigned LAT_FADD = DEF_LAT_FADD,
  parameter int unsigned LAT_FMUL = DEF_LAT_FMUL,
  parameter int unsigned LAT_CVT  = DEF_LAT_CVT,
  parameter int unsigned CNT_W    = 3
) (
  input  logic [2:0]       func,
  output logic [CNT_W-1:0] lat
);

  always_comb begin
    lat = CNT_W'(1);
    unique case (func)
      FUNC_MUL, FUNC_UMUL: lat = CNT_W'(LAT_IMUL);
      FUNC_ADDF, FUNC_SUBF: lat = CNT_W'(LAT_FADD);
      FUNC_MULF:            lat = CNT_W'(LAT_FMUL);
      FUNC_ITF, FUNC_FTI:   lat = CNT_W'(LAT_CVT);
      default:              lat = CNT_W'(1);
    endcase
  end

endmodule

// File: rtl/alu_ext_issue.sv
// Single-outstanding issuer for the multi-cycle ALU_EXT unit.
// Accepts one op from decode, holds its operands on alu_* while ALU_EXT
// computes, waits the func-dependent latency, captures the result and flags
// and presents them on wb_* until writeback accepts them.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      decode handshake; req_func/src1/src0/dst payload
//   flush                    abandon the op in flight (ignored when idle)
//   alu_src1/src0/func       held operands to ALU_EXT
//   alu_dst, alu_ov/zr/neg   ALU_EXT result and flags
//   wb_valid/wb_ready        writeback handshake; wb_data/dst/flags payload
//   stall                    req_valid & ~req_ready
//   illegal                  one-cycle trap pulse on func=111
// Build option: define ALU_EXT_ISSUE_TRAP_EN to trap func=111 and expose the
// illegal port; otherwise func=111 completes as latency 1 with data 0, zr=1.
module alu_ext_issue
  import alu_ext_issue_pkg::*;
#(
  parameter int unsigned LAT_IMUL = DEF_LAT_IMUL,
  parameter int unsigned LAT_FADD = DEF_LAT_FADD,
  parameter int unsigned LAT_FMUL = DEF_LAT_FMUL,
  parameter int unsigned LAT_CVT  = DEF_LAT_CVT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src0,
  input  logic [4:0]  req_dst,
  input  logic        flush,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src0,
  output logic [2:0]  alu_func,
  input  logic [31:0] alu_dst,
  input  logic        alu_ov,
  input  logic        alu_zr,
  input  logic        alu_neg,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dst,
  output logic [2:0]  wb_flags,
  output logic        stall
`ifdef ALU_EXT_ISSUE_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam int unsigned MaxLat = max_lat(LAT_IMUL, LAT_FADD, LAT_FMUL, LAT_CVT);
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      func_q;
  logic [31:0]     src1_q, src0_q;
  logic [4:0]      dst_q;
  logic            wb_valid_q;
  logic [31:0]     wb_data_q;
  logic [2:0]      wb_flags_q;
  logic [CntW-1:0] lat;
  logic            accept;
  logic            is_trap;

  alu_ext_lat_lut #(
    .LAT_IMUL (LAT_IMUL),
    .LAT_FADD (LAT_FADD),
    .LAT_FMUL (LAT_FMUL),
    .LAT_CVT  (LAT_CVT),
    .CNT_W    (CntW)
  ) u_lat_lut (
    .func (req_func),
    .lat  (lat)
  );

`ifdef ALU_EXT_ISSUE_TRAP_EN
  assign is_trap = (req_func == FUNC_UNDEF);
`else
  assign is_trap = 1'b0;
`endif

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign stall     = req_valid & ~req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      func_q     <= '0;
      src1_q     <= '0;
      src0_q     <= '0;
      dst_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && !is_trap) begin
            func_q  <= req_func;
            src1_q  <= req_src1;
            src0_q  <= req_src0;
            dst_q   <= req_dst;
            cnt_q   <= lat - CntW'(1);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (flush) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            // func=111 only reaches here untrapped: fixed zero result, zr set
            if (func_q == FUNC_UNDEF) begin
              wb_data_q  <= '0;
              wb_flags_q <= 3'b010;
            end else begin
              wb_data_q  <= alu_dst;
              wb_flags_q <= {alu_ov, alu_zr, alu_neg};
            end
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: begin
          // Result was captured on entry; valid rises one cycle later so the
          // writeback appears LAT+1 cycles after the accept edge.
          if (flush || (wb_valid_q && wb_ready)) begin
            wb_valid_q <= 1'b0;
            state_q    <= StIdle;
          end else begin
            wb_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_EXT_ISSUE_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept & is_trap;
    end
  end

  assign illegal = illegal_q;
`endif

  assign alu_src1 = src1_q;
  assign alu_src0 = src0_q;
  assign alu_func = func_q;
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_dst   = dst_q;
  assign wb_flags = wb_flags_q;

endmodule

// File: tb/tb_alu_ext_issue.sv
// Directed, scoreboarded bench for alu_ext_issue with a behavioural ALU_EXT stub.
module tb_alu_ext_issue;
  import alu_ext_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func;
  logic [31:0] req_src1, req_src0;
  logic [4:0]  req_dst;
  logic        flush;
  logic [31:0] alu_src1, alu_src0;
  logic [2:0]  alu_func;
  logic [31:0] alu_dst;
  logic        alu_ov, alu_zr, alu_neg;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic [2:0]  wb_flags;
  logic        stall;
`ifdef ALU_EXT_ISSUE_TRAP_EN
  logic        illegal;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dst;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_ext_issue #(
    .LAT_IMUL (2),
    .LAT_FADD (3),
    .LAT_FMUL (3),
    .LAT_CVT  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_func  (req_func),
    .req_src1  (req_src1),
    .req_src0  (req_src0),
    .req_dst   (req_dst),
    .flush     (flush),
    .alu_src1  (alu_src1),
    .alu_src0  (alu_src0),
    .alu_func  (alu_func),
    .alu_dst   (alu_dst),
    .alu_ov    (alu_ov),
    .alu_zr    (alu_zr),
    .alu_neg   (alu_neg),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_dst    (wb_dst),
    .wb_flags  (wb_flags),
    .stall     (stall)
`ifdef ALU_EXT_ISSUE_TRAP_EN
    ,
    .illegal   (illegal)
`endif
  );

  // ALU_EXT stub: combinational result from the held operands
  always_comb begin
    alu_dst = 32'hDEAD_BEEF;
    case (alu_func)
      FUNC_MUL, FUNC_UMUL: alu_dst = alu_src1 * alu_src0;
      FUNC_ADDF: alu_dst = (alu_src1 == 32'h3F80_0000 && alu_src0 == 32'h4000_0000) ?
                           32'h4040_0000 : alu_src1 + alu_src0;
      FUNC_SUBF: alu_dst = alu_src1 - alu_src0;
      FUNC_MULF: alu_dst = alu_src1 * alu_src0;
      FUNC_ITF:  alu_dst = ~alu_src1;
      FUNC_FTI:  alu_dst = alu_src1 >> 1;
      default:   alu_dst = 32'hDEAD_BEEF;
    endcase
  end

  assign alu_ov  = alu_dst[31] ^ alu_dst[30];
  assign alu_zr  = (alu_dst == 32'd0);
  assign alu_neg = alu_dst[31];

  function automatic exp_t mk(input logic [31:0] d, input logic [4:0] dst);
    exp_t e;
    e.data  = d;
    e.dst   = dst;
    e.flags = {d[31] ^ d[30], d == 32'd0, d[31]};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for writeback, compare against the scoreboard, then
  // optionally back-pressure for bp cycles before accepting it.
  task automatic run_op(input logic [2:0] f, input logic [31:0] s1, input logic [31:0] s0,
                        input logic [4:0] d, input int lat, input bit hold, input int bp,
                        input exp_t e);
    int   n;
    bit   stall_bad;
    exp_t got;
    sb.push_back(e);
    req_func  = f;
    req_src1  = s1;
    req_src0  = s0;
    req_dst   = d;
    req_valid = 1'b1;
    check("ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = hold;
    check("alu_func", 32'(alu_func), 32'(f));
    check("alu_src1", alu_src1, s1);
    check("alu_src0", alu_src0, s0);
    n = 0;
    stall_bad = 1'b0;
    while (!wb_valid && n < 20) begin
      if (hold && (stall !== 1'b1 || req_ready !== 1'b0)) stall_bad = 1'b1;
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(lat + 1));
    if (hold) begin
      check("stall_busy", 32'(stall_bad), 32'd0);
      check("stall_done", 32'(stall), 32'd1);
    end
    req_valid = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
      got = '0;
    end else begin
      got = sb.pop_front();
    end
    check("wb_data", wb_data, got.data);
    check("wb_dst", 32'(wb_dst), 32'(got.dst));
    check("wb_flags", 32'(wb_flags), 32'(got.flags));
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_valid", 32'(wb_valid), 32'd1);
      check("bp_data", wb_data, got.data);
      check("bp_dst", 32'(wb_dst), 32'(got.dst));
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("post_wb_valid", 32'(wb_valid), 32'd0);
    check("post_wb_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (wb_valid) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_func = '0;
    req_src1 = '0;
    req_src0 = '0;
    req_dst = '0;
    flush = 1'b0;
    wb_ready = 1'b0;
    repeat (2) tick();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_alu_src1", alu_src1, 32'd0);
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    tick();

    // MUL 7 * -3
    run_op(FUNC_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 2, 1'b0, 0, mk(32'hFFFF_FFEB, 5'd3));
    // ADDF 1.0 + 2.0 with a second request stalled behind it
    run_op(FUNC_ADDF, 32'h3F80_0000, 32'h4000_0000, 5'd12, 3, 1'b1, 0,
           mk(32'h4040_0000, 5'd12));
    // SUBF with a zero result
    run_op(FUNC_SUBF, 32'd10, 32'd10, 5'd7, 3, 1'b0, 0, mk(32'd0, 5'd7));
    // MULF held under back-pressure for 5 cycles
    run_op(FUNC_MULF, 32'h8000_0003, 32'd5, 5'd21, 3, 1'b0, 5, mk(32'h8000_000F, 5'd21));

    // FTI flushed one cycle after accept
    req_func = FUNC_FTI;
    req_src1 = 32'h0000_1234;
    req_src0 = 32'd0;
    req_dst = 5'd9;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", 32'(req_ready), 32'd1);
    check("flush_valid", 32'(wb_valid), 32'd0);
    expect_quiet("flush_no_wb", 6);
    run_op(FUNC_ITF, 32'h0000_00FF, 32'd0, 5'd30, 2, 1'b0, 0, mk(32'hFFFF_FF00, 5'd30));

    // func=111
`ifdef ALU_EXT_ISSUE_TRAP_EN
    req_func = FUNC_UNDEF;
    req_dst = 5'd4;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("illegal_pulse", 32'(illegal), 32'd1);
    check("illegal_ready", 32'(req_ready), 32'd1);
    tick();
    check("illegal_end", 32'(illegal), 32'd0);
    expect_quiet("illegal_no_wb", 4);
`else
    begin
      exp_t e;
      e.data = 32'd0;
      e.dst = 5'd4;
      e.flags = 3'b010;
      run_op(FUNC_UNDEF, 32'd5, 32'd6, 5'd4, 1, 1'b0, 0, e);
    end
`endif

    // Reset during WAIT of a UMUL
    req_func = FUNC_UMUL;
    req_src1 = 32'h0001_0000;
    req_src0 = 32'd3;
    req_dst = 5'd17;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_data", wb_data, 32'd0);
    check("mid_rst_dst", 32'(wb_dst), 32'd0);
    check("mid_rst_flags", 32'(wb_flags), 32'd0);
    check("mid_rst_src1", alu_src1, 32'd0);
    check("mid_rst_src0", alu_src0, 32'd0);
    check("mid_rst_func", 32'(alu_func), 32'd0);
`ifdef ALU_EXT_ISSUE_TRAP_EN
    check("mid_rst_illegal", 32'(illegal), 32'd0);
`endif
    tick();
    rst = 1'b0;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    expect_quiet("post_rst_no_wb", 6);

    // Recovery after reset
    run_op(FUNC_UMUL, 32'h0001_0000, 32'd3, 5'd17, 2, 1'b0, 0, mk(32'h0003_0000, 5'd17));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
